// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one ALU between two valid/ready requesters.
// Define ALU_SHARE_OPCNT_EN to add saturating per-requester op counters (op_cnt0/op_cnt1).
module alu_share_arbiter #(
   parameter int DATA_W = 4,
   parameter int OP_W   = 3,
   parameter int CNT_W  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              r0_valid,
   output logic              r0_ready,
   input  logic [DATA_W-1:0] r0_a,
   input  logic [DATA_W-1:0] r0_b,
   input  logic [OP_W-1:0]   r0_op,
   output logic              r0_rsp_valid,
   input  logic              r0_rsp_ready,
   input  logic              r1_valid,
   output logic              r1_ready,
   input  logic [DATA_W-1:0] r1_a,
   input  logic [DATA_W-1:0] r1_b,
   input  logic [OP_W-1:0]   r1_op,
   output logic              r1_rsp_valid,
   input  logic              r1_rsp_ready,
   output logic [DATA_W-1:0] rsp_result,
   output logic              rsp_carry,
   output logic              rsp_zero,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic [OP_W-1:0]   alu_op,
   input  logic [DATA_W-1:0] alu_result,
   input  logic              alu_carry,
   input  logic              alu_zero,
   output logic              busy,
   output logic              owner
`ifdef ALU_SHARE_OPCNT_EN
   ,
   output logic [CNT_W-1:0]  op_cnt0,
   output logic [CNT_W-1:0]  op_cnt1
`endif
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_EXEC = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   logic [1:0]        state_q, state_d;
   logic              last_grant_q, last_grant_d;
   logic              owner_q, owner_d;
   logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
   logic [OP_W-1:0]   op_q, op_d;
   logic [DATA_W-1:0] res_q, res_d;
   logic              carry_q, carry_d, zero_q, zero_d;
   logic              sel1;
   logic              idle;
   logic              rsp_done;

   // On a tie the requester that did not win last time gets the ALU.
   always_comb begin
      sel1 = 1'b0;
      if (r1_valid && !r0_valid) sel1 = 1'b1;
      else if (r0_valid && r1_valid) sel1 = ~last_grant_q;
   end

   assign idle     = (state_q == ST_IDLE);
   assign r0_ready = idle & r0_valid & ~sel1;
   assign r1_ready = idle & r1_valid & sel1;
   assign rsp_done = (state_q == ST_RESP) & (owner_q ? r1_rsp_ready : r0_rsp_ready);

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      owner_d      = owner_q;
      a_d          = a_q;
      b_d          = b_q;
      op_d         = op_q;
      res_d        = res_q;
      carry_d      = carry_q;
      zero_d       = zero_q;
      case (state_q)
         ST_IDLE: begin
            if (r0_ready || r1_ready) begin
               a_d          = sel1 ? r1_a  : r0_a;
               b_d          = sel1 ? r1_b  : r0_b;
               op_d         = sel1 ? r1_op : r0_op;
               owner_d      = sel1;
               last_grant_d = sel1;
               state_d      = ST_EXEC;
            end
         end
         ST_EXEC: begin
            res_d   = alu_result;
            carry_d = alu_carry;
            zero_d  = alu_zero;
            state_d = ST_RESP;
         end
         ST_RESP: begin
            if (rsp_done) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         last_grant_q <= 1'b1;
         owner_q      <= 1'b0;
         a_q          <= '0;
         b_q          <= '0;
         op_q         <= '0;
         res_q        <= '0;
         carry_q      <= 1'b0;
         zero_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         owner_q      <= owner_d;
         a_q          <= a_d;
         b_q          <= b_d;
         op_q         <= op_d;
         res_q        <= res_d;
         carry_q      <= carry_d;
         zero_q       <= zero_d;
      end
   end

   assign alu_a        = a_q;
   assign alu_b        = b_q;
   assign alu_op       = op_q;
   assign rsp_result   = res_q;
   assign rsp_carry    = carry_q;
   assign rsp_zero     = zero_q;
   assign r0_rsp_valid = (state_q == ST_RESP) & ~owner_q;
   assign r1_rsp_valid = (state_q == ST_RESP) & owner_q;
   assign busy         = ~idle;
   assign owner        = owner_q;

`ifdef ALU_SHARE_OPCNT_EN
   logic [CNT_W-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;

   // Counters stick at all-ones instead of wrapping.
   always_comb begin
      cnt0_d = cnt0_q;
      cnt1_d = cnt1_q;
      if (rsp_done && !owner_q && !(&cnt0_q)) cnt0_d = cnt0_q + 1'b1;
      if (rsp_done && owner_q && !(&cnt1_q))  cnt1_d = cnt1_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt0_q <= '0;
         cnt1_q <= '0;
      end else begin
         cnt0_q <= cnt0_d;
         cnt1_q <= cnt1_d;
      end
   end

   assign op_cnt0 = cnt0_q;
   assign op_cnt1 = cnt1_q;
`endif

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one 4-bit ALU between two requesters, R0 and R1.
- Each requester has a valid/ready command channel (operands plus opcode) and a valid/ready response channel.
- Round-robin arbitration. One operation in flight at a time. Results are held until the response is accepted.
- Sits between two command sources (e.g. sequencer and debug port) and the shared ALU, which it drives through dedicated ALU-side ports.

Parameters:
- DATA_W, 4: operand/result width; must match the ALU.
- OP_W, 3: opcode width.
- CNT_W, 8: width of the optional per-requester op counters.

Ports:
- clk  input  1  clock; all logic on rising edge
- rst  input  1  synchronous active-high reset
- r0_valid  input  1  R0 command valid
- r0_ready  output  1  R0 command accepted this cycle
- r0_a  input  DATA_W  R0 operand A
- r0_b  input  DATA_W  R0 operand B
- r0_op  input  OP_W  R0 opcode
- r0_rsp_valid  output  1  response valid for R0
- r0_rsp_ready  input  1  R0 takes response
- r1_valid, r1_ready, r1_a, r1_b, r1_op, r1_rsp_valid, r1_rsp_ready: same as R0, for R1
- rsp_result  output  DATA_W  captured ALU result; shared by both requesters
- rsp_carry  output  1  captured ALU carry
- rsp_zero  output  1  captured ALU zero flag
- alu_a  output  DATA_W  operand A to ALU
- alu_b  output  DATA_W  operand B to ALU
- alu_op  output  OP_W  opcode to ALU
- alu_result  input  DATA_W  ALU result
- alu_carry  input  1  ALU carry/borrow/shift-out
- alu_zero  input  1  ALU zero flag
- busy  output  1  high when state is not IDLE
- owner  output  1  requester owning the current operation (0/1)

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- States: IDLE, EXEC, RESP. Encoding is free.
- IDLE:
  - If exactly one of r0_valid/r1_valid is high, select it.
  - If both are high, select the requester NOT equal to last_grant.
  - rN_ready = (state==IDLE) & selected(N). Combinational from valid and last_grant; at most one ready is high.
  - On handshake: capture a, b, op into operand registers; owner<=N; last_grant<=N; go to EXEC.
  - With no valid, stay in IDLE.
- EXEC:
  - alu_a/alu_b/alu_op are always driven from the operand registers, never combinationally from requester inputs.
  - In this cycle the ALU outputs are sampled into rsp_result/rsp_carry/rsp_zero. Go to RESP.
- RESP:
  - r{owner}_rsp_valid=1; the other rsp_valid=0.
  - Response registers hold stable until r{owner}_rsp_ready=1, then go to IDLE.
  - The non-owner's rsp_ready is ignored.
- Latency: handshake at cycle T; rsp_valid at T+2. Minimum 3 cycles per operation. A new command can be accepted no earlier than the cycle after the response is consumed.
- Both ready outputs are 0 in EXEC and RESP; pending valids wait. Requesters must hold valid and payload until ready.
- Fairness: under continuous requests from both, grants strictly alternate.
- Reset values:
  - state=IDLE, last_grant=1 (so R0 wins the first tie), owner=0.
  - Operand registers 0; alu_a=0, alu_b=0, alu_op=0.
  - rsp_result=0, rsp_carry=0, rsp_zero=0; all rsp_valid=0; busy=0.
- Reset mid-operation: the in-flight op is discarded and no response is issued. A requester whose command was accepted must reissue it.
- The arbiter does not interpret opcodes. Result, carry and zero are passed through exactly as sampled.

Optional Feature:
- Macro: ALU_SHARE_OPCNT_EN.
- Defined:
  - Adds outputs op_cnt0 and op_cnt1, each CNT_W wide.
  - Each increments on the completed response handshake of its requester.
  - Saturates at all-ones; no wrap.
  - Reset to 0.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Single op, R0 only: r0 a=9, b=8, op=000 with the real ALU attached -> r0_ready in the same cycle; r0_rsp_valid 2 cycles later with result=1, carry=1, zero=0; r1_rsp_valid stays 0.
- Tie after reset: both valid, R0 a=3 b=5 op=001, R1 a=10 op=110 -> R0 served first (result=14, carry=1); then R1 (result=4, carry=1); owner goes 0 then 1.
- Response backpressure: hold r0_rsp_ready=0 for 5 cycles -> rsp_valid and rsp_result stable; busy=1; r1_ready stays 0 despite r1_valid; completes the cycle after ready rises.
- Continuous dual requests, 6 ops -> grant order 0,1,0,1,0,1; each op takes exactly 3 cycles when rsp_ready is tied high.
- Reset mid-EXEC: assert rst during EXEC -> next cycle state is IDLE; no rsp_valid; all outputs at reset values; a fresh R1 request is then served normally.
- With ALU_SHARE_OPCNT_EN: preload to 255 (CNT_W=8) by running 256 R0 ops -> op_cnt0 stays 255; op_cnt1 counts only R1 ops.
